// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;
   localparam int MIN_DIV = 2;
   localparam int DEFAULT_DATA_BITS = 8;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: single-clock bit timer, one-cycle tick every div clk_in cycles.
module baud_tick_gen #(
   parameter int DIV_W = 32
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;
   assign tick = cnt == div - DIV_W'(1);
   always_ff @(posedge clk_in or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer (start, data LSB first, optional parity, 1/2 stop bits)
// with a runtime-programmable single-clock bit timer.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEFAULT_DATA_BITS,
   parameter int DIV_W     = 32
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [DIV_W-1:0]     div_factor,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 cfg_err
);
   localparam logic [3:0] IDX_LAST = 4'(DATA_BITS - 1);
   tx_state_e            state, state_n;
   logic [DIV_W-1:0]     div_r;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [3:0]           idx;
   logic                 stop_cnt, par_en_r, stop2_r, par_r;
   logic                 bit_done, legal, accept;
   logic                 tx_n, ready_n, busy_n, err_n;

   assign legal  = div_factor >= DIV_W'(MIN_DIV);
   // the legality term also guards against div_factor turning illegal on the handshake cycle
   assign accept = state == IDLE && tx_valid && tx_ready && legal;
   assign sh_n   = (state == DATA && bit_done) ? sh >> 1 : sh;

   baud_tick_gen #(.DIV_W(DIV_W)) u_baud (
      .clk_in (clk_in),
      .reset  (reset),
      .clear  (accept),
      .div    (div_r),
      .tick   (bit_done)
   );

   always_ff @(posedge clk_in or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = START;
         START:   if (bit_done) state_n = DATA;
         DATA:    if (bit_done && idx == IDX_LAST) state_n = par_en_r ? PARITY : STOP;
         PARITY:  if (bit_done) state_n = STOP;
         STOP:    if (bit_done && stop_cnt == stop2_r) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // outputs are derived from the next state so they register in step with it
   always_comb begin
      tx_n    = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_r : 1'b1;
      busy_n  = state_n != IDLE;
      ready_n = state_n == IDLE && legal;
      err_n   = state_n == IDLE && !legal;
   end

   always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
         tx       <= 1'b1;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         tx       <= tx_n;
         tx_ready <= ready_n;
         busy     <= busy_n;
         cfg_err  <= err_n;
      end

   always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
         div_r    <= '0;
         sh       <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         par_en_r <= 1'b0;
         stop2_r  <= 1'b0;
         par_r    <= 1'b0;
      end else if (accept) begin
         div_r    <= div_factor;
         sh       <= tx_data;
         idx      <= '0;
         stop_cnt <= 1'b0;
         par_en_r <= parity_en;
         stop2_r  <= stop2;
         par_r    <= ^tx_data ^ parity_odd;
      end else begin
         sh <= sh_n;
         if (state == DATA && bit_done) idx <= idx + 4'd1;
         if (state == STOP && bit_done) stop_cnt <= 1'b1;
      end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl, cycle-exact check of every serial frame.
module tb_uart_tx_ctrl;
   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] div_factor = '0;
   logic        parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, tx, busy, cfg_err;
   int          vectors = 0, errors = 0;
   bit          exp_q[$];

   uart_tx_ctrl #(.DATA_BITS(8), .DIV_W(32)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .div_factor (div_factor),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .cfg_err    (cfg_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic push_bit(input bit v, input int dv);
      repeat (dv) exp_q.push_back(v);
   endtask

   // chg > 0: at that frame cycle every config input and tx_data are disturbed
   task automatic do_frame(input logic [7:0] d, input int dv, input bit pen, input bit podd,
                           input bit s2, input bit hold, input int chg);
      int t = 0;
      bit e;
      while (tx_ready !== 1'b1 && t < 200) begin
         @(negedge clk_in);
         t++;
      end
      vectors++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait: tx_ready=%b required 1", tx_ready);
         return;
      end
      div_factor = dv;
      parity_en  = pen;
      parity_odd = podd;
      stop2      = s2;
      tx_data    = d;
      tx_valid   = 1'b1;
      push_bit(1'b0, dv);
      for (int i = 0; i < 8; i++) push_bit(d[i], dv);
      if (pen) push_bit((^d) ^ podd, dv);
      push_bit(1'b1, s2 ? 2 * dv : dv);
      @(negedge clk_in);
      if (!hold) tx_valid = 1'b0;
      for (int i = 1; exp_q.size() > 0; i++) begin
         if (i > 1) @(negedge clk_in);
         if (i == chg) begin
            div_factor = 8;
            tx_data    = ~d;
            parity_en  = ~pen;
            parity_odd = ~podd;
            stop2      = ~s2;
         end
         e = exp_q.pop_front();
         vectors++;
         if ({tx, busy, tx_ready} !== {e, 2'b10}) begin
            errors++;
            $display("FAIL frame_bit d=%h cycle %0d: tx,busy,ready=%b%b%b required %b10", d, i, tx, busy, tx_ready, e);
         end
      end
      @(negedge clk_in);
      vectors++;
      if ({tx, busy, tx_ready} !== 3'b101) begin
         errors++;
         $display("FAIL frame_end d=%h: tx,busy,ready=%b%b%b required 101", d, tx, busy, tx_ready);
      end
   endtask

   task automatic test_reset;
      @(negedge clk_in);
      vectors++;
      if ({tx, tx_ready, busy, cfg_err} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_state: tx,ready,busy,err=%b%b%b%b required 1000", tx, tx_ready, busy, cfg_err);
      end
      reset = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({tx, tx_ready, cfg_err} !== 3'b101) begin
         errors++;
         $display("FAIL reset_div0: tx,ready,err=%b%b%b required 101", tx, tx_ready, cfg_err);
      end
      div_factor = 4;
      @(negedge clk_in);
      vectors++;
      if ({tx_ready, cfg_err} !== 2'b10) begin
         errors++;
         $display("FAIL reset_div4: ready,err=%b%b required 10", tx_ready, cfg_err);
      end
   endtask

   task automatic test_8n1;
      do_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_parity;
      do_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      do_frame(8'hA5, 4, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      do_frame(8'h07, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_back_to_back;
      do_frame(8'h00, 3, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      do_frame(8'h81, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
   endtask

   task automatic test_illegal_div;
      div_factor = 1;
      @(negedge clk_in);
      tx_valid = 1'b1;
      repeat (3) begin
         @(negedge clk_in);
         vectors++;
         if ({tx, tx_ready, busy, cfg_err} !== 4'b1001) begin
            errors++;
            $display("FAIL illegal_div: tx,ready,busy,err=%b%b%b%b required 1001", tx, tx_ready, busy, cfg_err);
         end
      end
      div_factor = 10;
      @(negedge clk_in);
      vectors++;
      if ({tx_ready, cfg_err} !== 2'b10) begin
         errors++;
         $display("FAIL legal_again: ready,err=%b%b required 10", tx_ready, cfg_err);
      end
      do_frame(8'hC3, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_div_change;
      do_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 10);
      do_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_reset_mid;
      div_factor = 4;
      tx_data    = 8'hA5;
      tx_valid   = 1'b1;
      @(negedge clk_in);
      tx_valid = 1'b0;
      repeat (9) @(negedge clk_in);
      vectors++;
      if ({tx, busy} !== 2'b01) begin
         errors++;
         $display("FAIL pre_reset: tx,busy=%b%b required 01", tx, busy);
      end
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({tx, busy, tx_ready} !== 3'b100) begin
         errors++;
         $display("FAIL async_reset: tx,busy,ready=%b%b%b required 100", tx, busy, tx_ready);
      end
      @(negedge clk_in);
      reset = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({tx_ready, cfg_err, busy} !== 3'b100) begin
         errors++;
         $display("FAIL post_reset: ready,err,busy=%b%b%b required 100", tx_ready, cfg_err, busy);
      end
      do_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_parity;
      test_back_to_back;
      test_illegal_div;
      test_div_change;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
